video_timing_1080p60: RTL and testbench

Generates CEA-861 1920x1080p60 raster timing (hsync, vsync, data-enable, pixel coordinates) in the 148.5 MHz pixel clock domain. It sits directly downstream of the pixel PLL: it consumes the PLL output clock and the PLL `locked` flag. Its outputs drive the overlay pixel source and the HDMI transmitter.
The block gates the raster on a synchronised, debounced lock, so no partial or glitched frames reach the transmitter.

---
 rtl/video_timing_1080p60_if.sv | 31 +++
 rtl/video_timing_1080p60.sv | 163 ++++++++++++++++
 tb/tb_video_timing_1080p60.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_1080p60_if.sv
// Raster output bundle of the 1080p60 timing generator.
// master: the timing generator drives every signal.
// slave : downstream consumers (overlay pixel source, HDMI transmitter).
// Signals:
//   hsync, vsync       : sync pulses at the generator's configured polarity
//   de                 : data enable, high for active pixels
//   x (12b), y (11b)   : active pixel coordinate, zero outside the active area
//   line_start         : one-cycle pulse on the first pixel of each active line
//   frame_start        : one-cycle pulse on pixel (0,0)
//   running            : raster is being generated
// Handshake: there is no back-pressure. Every signal is valid on each pixclk
// cycle and consumers must accept it; de plays the role of a valid strobe
// and no ready exists.
interface video_timing_1080p60_if;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [11:0] x;
  logic [10:0] y;
  logic        line_start;
  logic        frame_start;
  logic        running;

  modport master (
    output hsync, vsync, de, x, y, line_start, frame_start, running
  );

  modport slave (
    input hsync, vsync, de, x, y, line_start, frame_start, running
  );
endinterface

// File: rtl/video_timing_1080p60.sv
// CEA-861 1920x1080p60 raster timing generator (pixclk domain, 148.5 MHz).
// The raster only starts after the PLL lock flag has been synchronised and
// seen high for SETTLE_CYCLES consecutive cycles; losing lock abandons the
// current frame at once and returns all outputs to their idle levels.
// Ports:
//   pixclk  : pixel clock from the PLL
//   rst_n   : asynchronous active-low reset
//   locked  : PLL lock flag, asynchronous to pixclk
//   vid     : raster outputs (video_timing_1080p60_if.master), all registered
//   state_o : current FSM state (0 WAIT_LOCK, 1 SETTLE, 2 RUN) for debug
module video_timing_1080p60 #(
  parameter int H_ACTIVE      = 1920,
  parameter int H_FP          = 88,
  parameter int H_SYNC        = 44,
  parameter int H_BP          = 148,
  parameter int V_ACTIVE      = 1080,
  parameter int V_FP          = 4,
  parameter int V_SYNC        = 5,
  parameter int V_BP          = 36,
  parameter bit HS_POL        = 1'b1,
  parameter bit VS_POL        = 1'b1,
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic                          pixclk,
  input  logic                          rst_n,
  input  logic                          locked,
  video_timing_1080p60_if.master        vid,
  output logic [1:0]                    state_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = V_ACTIVE + V_FP + V_SYNC;
  localparam int SC_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);

  if (H_TOTAL > 4096) begin : g_h_total_too_big
    $error("H_TOTAL exceeds the 12-bit horizontal counter");
  end
  if (V_TOTAL > 2048) begin : g_v_total_too_big
    $error("V_TOTAL exceeds the 11-bit vertical counter");
  end
  if (SETTLE_CYCLES < 1) begin : g_settle_too_small
    $error("SETTLE_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t          state_q;
  logic            lk_meta_q;
  logic            lk_s_q;
  logic [SC_W-1:0] settle_cnt_q;
  logic [11:0]     h_cnt_q;
  logic [10:0]     v_cnt_q;
  logic [11:0]     h_cnt_d;
  logic [10:0]     v_cnt_d;

  logic de_c, hs_act_c, vs_act_c, h_last_c, v_last_c;

  // Decode of the current raster position; registered into the outputs below.
  always_comb begin
    h_last_c = (int'(h_cnt_q) == H_TOTAL - 1);
    v_last_c = (int'(v_cnt_q) == V_TOTAL - 1);
    de_c     = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
    hs_act_c = (int'(h_cnt_q) >= HS_BEG) && (int'(h_cnt_q) < HS_END);
    // vsync depends on v only, so its edges fall on h_cnt = 0.
    vs_act_c = (int'(v_cnt_q) >= VS_BEG) && (int'(v_cnt_q) < VS_END);

    h_cnt_d = h_cnt_q + 12'd1;
    v_cnt_d = v_cnt_q;
    if (h_last_c) begin
      h_cnt_d = 12'd0;
      v_cnt_d = v_last_c ? 11'd0 : v_cnt_q + 11'd1;
    end
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= WAIT_LOCK;
      lk_meta_q       <= 1'b0;
      lk_s_q          <= 1'b0;
      settle_cnt_q    <= '0;
      h_cnt_q         <= '0;
      v_cnt_q         <= '0;
      vid.hsync       <= ~HS_POL;
      vid.vsync       <= ~VS_POL;
      vid.de          <= 1'b0;
      vid.x           <= '0;
      vid.y           <= '0;
      vid.line_start  <= 1'b0;
      vid.frame_start <= 1'b0;
      vid.running     <= 1'b0;
    end else begin
      lk_meta_q <= locked;
      lk_s_q    <= lk_meta_q;

      // Idle output levels unless a RUN cycle below overrides them.
      vid.hsync       <= ~HS_POL;
      vid.vsync       <= ~VS_POL;
      vid.de          <= 1'b0;
      vid.x           <= '0;
      vid.y           <= '0;
      vid.line_start  <= 1'b0;
      vid.frame_start <= 1'b0;
      vid.running     <= 1'b0;

      case (state_q)
        WAIT_LOCK: begin
          settle_cnt_q <= '0;
          h_cnt_q      <= '0;
          v_cnt_q      <= '0;
          if (lk_s_q) state_q <= SETTLE;
        end

        SETTLE: begin
          if (!lk_s_q) begin
            state_q      <= WAIT_LOCK;
            settle_cnt_q <= '0;
          end else if (settle_cnt_q == SETTLE_LAST) begin
            state_q      <= RUN;
            settle_cnt_q <= '0;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
          end else begin
            settle_cnt_q <= settle_cnt_q + 1'b1;
          end
        end

        RUN: begin
          if (!lk_s_q) begin
            // Lost lock: drop the frame, outputs keep the idle defaults.
            state_q <= WAIT_LOCK;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
          end else begin
            vid.running     <= 1'b1;
            vid.de          <= de_c;
            vid.x           <= de_c ? h_cnt_q : 12'd0;
            vid.y           <= de_c ? v_cnt_q : 11'd0;
            vid.hsync       <= hs_act_c ? HS_POL : ~HS_POL;
            vid.vsync       <= vs_act_c ? VS_POL : ~VS_POL;
            vid.line_start  <= (h_cnt_q == 12'd0) && (int'(v_cnt_q) < V_ACTIVE);
            vid.frame_start <= (h_cnt_q == 12'd0) && (v_cnt_q == 11'd0);
            h_cnt_q         <= h_cnt_d;
            v_cnt_q         <= v_cnt_d;
          end
        end

        default: state_q <= WAIT_LOCK;
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_video_timing_1080p60.sv
// Bench for video_timing_1080p60 using a shrunken raster (32x20 total,
// 20x12 active) and a 64-cycle settle so full frames fit in a short run.
module tb_video_timing_1080p60;
  localparam int HA = 20, HFP = 4, HSW = 3, HBP = 5;
  localparam int VA = 12, VFP = 2, VSW = 3, VBP = 3;
  localparam int HT = HA + HFP + HSW + HBP;   // 32
  localparam int VT = VA + VFP + VSW + VBP;   // 20
  localparam int FRAME = HT * VT;             // 640
  localparam int S = 64;
  localparam int W = 29;

  logic       pixclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic       locked = 1'b0;
  logic [1:0] state_o;

  video_timing_1080p60_if vif();

  video_timing_1080p60 #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b1), .VS_POL(1'b1), .SETTLE_CYCLES(S)
  ) dut (
    .pixclk (pixclk),
    .rst_n  (rst_n),
    .locked (locked),
    .vid    (vif),
    .state_o(state_o)
  );

  // ---------------- clock ----------------
  always #5 pixclk = ~pixclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] pk(logic r, logic hs, logic vs, logic de,
                                      logic ls, logic fs, logic [11:0] x,
                                      logic [10:0] y);
    return {r, hs, vs, de, ls, fs, x, y};
  endfunction

  logic [W-1:0] act_v;
  assign act_v = pk(vif.running, vif.hsync, vif.vsync, vif.de,
                    vif.line_start, vif.frame_start, vif.x, vif.y);

  localparam logic [W-1:0] RST_V = {W{1'b0}};

  int chk_total = 0;
  int chk_pass  = 0;

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    chk_total++;
    if (a === e) chk_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, a, e);
  endtask

  // Counts negedges until running is seen high; -1 if the budget expires.
  task automatic wait_running(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge pixclk);
      if (vif.running === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // ---------------- vector table / scoreboard ----------------
  typedef struct {
    int           off;
    logic [W-1:0] exp;
  } vec_t;

  vec_t         tbl[20];
  logic [W-1:0] exp_q[$];
  int           off_q[$];

  task automatic setv(input int i, input int h, input int v, input logic [W-1:0] e);
    tbl[i].off = v * HT + h;
    tbl[i].exp = e;
  endtask

  // ---------------- main test ----------------
  initial begin
    int n;
    int fs_cnt, ls_cnt, de_cnt, hs_cnt, vs_cnt, first_hs, first_vs, fs2_off;

    setv( 0,  0,  0, pk(1,0,0,1,1,1, 0, 0));
    setv( 1,  1,  0, pk(1,0,0,1,0,0, 1, 0));
    setv( 2, 19,  0, pk(1,0,0,1,0,0,19, 0));
    setv( 3, 20,  0, pk(1,0,0,0,0,0, 0, 0));
    setv( 4, 23,  0, pk(1,0,0,0,0,0, 0, 0));
    setv( 5, 24,  0, pk(1,1,0,0,0,0, 0, 0));
    setv( 6, 26,  0, pk(1,1,0,0,0,0, 0, 0));
    setv( 7, 27,  0, pk(1,0,0,0,0,0, 0, 0));
    setv( 8,  0,  1, pk(1,0,0,1,1,0, 0, 1));
    setv( 9,  5,  7, pk(1,0,0,1,0,0, 5, 7));
    setv(10, 19, 11, pk(1,0,0,1,0,0,19,11));
    setv(11, 20, 11, pk(1,0,0,0,0,0, 0, 0));
    setv(12,  0, 12, pk(1,0,0,0,0,0, 0, 0));
    setv(13, 25, 12, pk(1,1,0,0,0,0, 0, 0));
    setv(14, 31, 13, pk(1,0,0,0,0,0, 0, 0));
    setv(15,  0, 14, pk(1,0,1,0,0,0, 0, 0));
    setv(16, 25, 14, pk(1,1,1,0,0,0, 0, 0));
    setv(17, 31, 16, pk(1,0,1,0,0,0, 0, 0));
    setv(18,  0, 17, pk(1,0,0,0,0,0, 0, 0));
    setv(19,  0, 20, pk(1,0,0,1,1,1, 0, 0));
    foreach (tbl[i]) begin
      exp_q.push_back(tbl[i].exp);
      off_q.push_back(tbl[i].off);
    end

    // Reset state
    repeat (4) @(negedge pixclk);
    check("reset_outputs", act_v, RST_V);
    check("reset_state", state_o, 2'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge pixclk);
    check("idle_no_lock", act_v, RST_V);
    check("idle_state", state_o, 2'd0);

    // Lock: 2 sync + WAIT_LOCK cycle + S settle cycles + first RUN cycle
    locked = 1'b1;
    wait_running(S + 20, n);
    check("lock_latency", n, S + 4);

    // One full frame plus the first pixel of the next
    fs_cnt = 0; ls_cnt = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    first_hs = -1; first_vs = -1; fs2_off = -1;
    for (int off = 0; off <= FRAME; off++) begin
      if (off > 0) @(negedge pixclk);
      if (off < FRAME) begin
        fs_cnt += int'(vif.frame_start);
        ls_cnt += int'(vif.line_start);
        de_cnt += int'(vif.de);
        hs_cnt += int'(vif.hsync);
        vs_cnt += int'(vif.vsync);
        if (first_hs < 0 && vif.hsync) first_hs = off;
        if (first_vs < 0 && vif.vsync) first_vs = off;
      end
      if (off > 0 && fs2_off < 0 && vif.frame_start) fs2_off = off;
      if (off_q.size() > 0 && off_q[0] == off) begin
        check($sformatf("vec_off%0d", off), act_v, exp_q.pop_front());
        void'(off_q.pop_front());
      end
    end
    check("table_drained", exp_q.size(), 0);
    check("frame_start_count", fs_cnt, 1);
    check("frame_period", fs2_off, FRAME);
    check("line_start_count", ls_cnt, VA);
    check("de_count", de_cnt, HA * VA);
    check("hsync_count", hs_cnt, HSW * VT);
    check("hsync_first_pos", first_hs, HA + HFP);
    check("vsync_count", vs_cnt, VSW * HT);
    check("vsync_first_pos", first_vs, (VA + VFP) * HT);

    // Lock drop mid-frame at line 5, pixel 7
    repeat (5 * HT + 7) @(negedge pixclk);
    check("pre_drop_pos", act_v, pk(1,0,0,1,0,0,7,5));
    locked = 1'b0;
    repeat (2) @(negedge pixclk);
    check("drop_sync_delay", vif.running, 1'b1);
    @(negedge pixclk);
    check("drop_outputs_idle", act_v, RST_V);
    check("drop_state", state_o, 2'd0);
    locked = 1'b1;
    wait_running(S + 20, n);
    check("relock_latency", n, S + 4);
    check("relock_first_pixel", act_v, pk(1,0,0,1,1,1,0,0));

    // Lock glitch of 4 cycles while settling
    locked = 1'b0;
    repeat (3) @(negedge pixclk);
    check("glitch_pre_idle", act_v, RST_V);
    locked = 1'b1;
    repeat (3 + 40) @(negedge pixclk);
    check("settling_state", state_o, 2'd1);
    locked = 1'b0;
    repeat (4) @(negedge pixclk);
    check("settle_abort_state", state_o, 2'd0);
    locked = 1'b1;
    wait_running(S + 20, n);
    check("settle_restart_latency", n, S + 4);

    // Asynchronous reset mid-line
    repeat (10) @(negedge pixclk);
    check("pre_reset_pos", act_v, pk(1,0,0,1,0,0,10,0));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", act_v, RST_V);
    repeat (3) @(negedge pixclk);
    check("reset_hold_state", state_o, 2'd0);
    rst_n = 1'b1;
    wait_running(S + 20, n);
    check("post_reset_latency", n, S + 4);
    check("post_reset_first_pixel", act_v, pk(1,0,0,1,1,1,0,0));

    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
